// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline control slice: FSM state encodings,
// the HLT opcode, the NOP instruction word, and the per-cycle control bundle
// that the controller drives onto the pipeline registers.
package pipeline_ctrl_pkg;

  localparam int unsigned STATE_W = 2;
  localparam int unsigned OPC_W   = 4;
  localparam int unsigned INSTR_W = 16;

  // FSM state encodings (kept as plain constants for legacy compatibility)
  localparam logic [STATE_W-1:0] PC_RUN    = 2'd0;
  localparam logic [STATE_W-1:0] PC_DRAIN  = 2'd1;
  localparam logic [STATE_W-1:0] PC_HALTED = 2'd2;

  localparam logic [OPC_W-1:0]   OPC_HLT   = 4'b1111;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0000;

  // Per-cycle enables for PC and the four pipeline registers
  typedef struct packed {
    logic pc_we;
    logic fd_we;
    logic fd_flush;
    logic dx_we;
    logic dx_bubble;
    logic xm_we;
    logic mw_we;
  } ctrl_t;

  // Every write enable set to en, no flush, no bubble
  function automatic ctrl_t ctrl_all_we(input logic en);
    ctrl_t c;
    c           = '0;
    c.pc_we     = en;
    c.fd_we     = en;
    c.dx_we     = en;
    c.xm_we     = en;
    c.mw_we     = en;
    return c;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter used for the pipeline performance counters.
// Ports: clk, rst_n (async active-low clear), inc (count this edge),
//        clear (synchronous clear), count (current value, holds at all-ones).
module pipeline_ctrl_sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clear,
  output logic [CNT_W-1:0] count
);

  // Saturating increment; synchronous clear wins over increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline controller: turns hazard-unit stalls, ID-stage branch/halt decode
// and data-memory busy into PC / pipeline-register enables, IF/ID flush and
// ID/EX bubble insertion. A HLT drains EX/MEM/WB, then parks the core until
// reset.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   stall_sig, fd_branchtaken,
//   fd_halt, dmem_busy              control inputs
//   pc_we, fd_we, fd_flush, dx_we,
//   dx_bubble, xm_we, mw_we         combinational enables (zero in reset)
//   halted                          registered park indication
//   stall_cycles, flush_cycles      perf counters (PIPE_PERF_CNT_EN only)
// Build option: define PIPE_PERF_CNT_EN to add the saturating perf counters.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = 3
`ifdef PIPE_PERF_CNT_EN
  ,
  parameter int unsigned CNT_W        = 16
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_sig,
  input  logic             fd_branchtaken,
  input  logic             fd_halt,
  input  logic             dmem_busy,
  output logic             pc_we,
  output logic             fd_we,
  output logic             fd_flush,
  output logic             dx_we,
  output logic             dx_bubble,
  output logic             xm_we,
  output logic             mw_we,
  output logic             halted
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_cycles
`endif
);

  localparam int unsigned DCNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DCNT_W-1:0] DRAIN_LAST = DCNT_W'(DRAIN_CYCLES - 1);

  logic [STATE_W-1:0] state_q, state_d;
  logic [DCNT_W-1:0]  cnt_q, cnt_d;
  logic               halted_q;
  ctrl_t              ctrl_c;
  logic               stall_hon_c;

  // State, drain counter and registered halted flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= PC_RUN;
      cnt_q    <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      halted_q <= (state_d == PC_HALTED);
    end
  end

  // Next state and combinational enables; everything low while in reset
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ctrl_c      = '0;
    stall_hon_c = 1'b0;
    if (rst_n) begin
      case (state_q)
        PC_RUN: begin
          if (dmem_busy) begin
            ctrl_c = '0;
          end else if (stall_sig) begin
            // Hold PC and IF/ID, push a bubble into EX
            ctrl_c           = ctrl_all_we(1'b1);
            ctrl_c.pc_we     = 1'b0;
            ctrl_c.fd_we     = 1'b0;
            ctrl_c.dx_bubble = 1'b1;
            stall_hon_c      = 1'b1;
          end else if (fd_branchtaken) begin
            ctrl_c          = ctrl_all_we(1'b1);
            ctrl_c.fd_flush = 1'b1;
          end else if (fd_halt) begin
            // HLT moves on to EX; nothing behind it is fetched
            ctrl_c          = ctrl_all_we(1'b1);
            ctrl_c.pc_we    = 1'b0;
            ctrl_c.fd_flush = 1'b1;
            state_d         = PC_DRAIN;
            cnt_d           = '0;
          end else begin
            ctrl_c = ctrl_all_we(1'b1);
          end
        end
        PC_DRAIN: begin
          // Feed NOPs from ID while EX/MEM/WB empty out; the ID/EX load also
          // waits on memory so the instruction in EX is not overwritten
          ctrl_c.fd_flush  = 1'b1;
          ctrl_c.dx_bubble = 1'b1;
          ctrl_c.dx_we     = !dmem_busy;
          ctrl_c.xm_we     = !dmem_busy;
          ctrl_c.mw_we     = !dmem_busy;
          if (!dmem_busy) begin
            if (cnt_q == DRAIN_LAST) begin
              state_d = PC_HALTED;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + DCNT_W'(1);
            end
          end
        end
        PC_HALTED: begin
          ctrl_c = '0;
        end
        default: begin
          state_d = PC_RUN;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign pc_we     = ctrl_c.pc_we;
  assign fd_we     = ctrl_c.fd_we;
  assign fd_flush  = ctrl_c.fd_flush;
  assign dx_we     = ctrl_c.dx_we;
  assign dx_bubble = ctrl_c.dx_bubble;
  assign xm_we     = ctrl_c.xm_we;
  assign mw_we     = ctrl_c.mw_we;
  assign halted    = halted_q;

`ifdef PIPE_PERF_CNT_EN
  // Counts edges where a stall was honoured / IF/ID was flushed
  pipeline_ctrl_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_hon_c),
    .clear (1'b0),
    .count (stall_cycles)
  );

  pipeline_ctrl_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (ctrl_c.fd_flush),
    .clear (1'b0),
    .count (flush_cycles)
  );
`else
  logic unused_c;
  assign unused_c = stall_hon_c;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: expected control vectors are queued when
// each step is driven and popped when the outputs are sampled mid-cycle.
module tb_pipeline_ctrl;

  logic clk;
  logic rst_n;
  logic stall_sig;
  logic fd_branchtaken;
  logic fd_halt;
  logic dmem_busy;
  logic pc_we, fd_we, fd_flush, dx_we, dx_bubble, xm_we, mw_we, halted;
`ifdef PIPE_PERF_CNT_EN
  logic [15:0] stall_cycles;
  logic [15:0] flush_cycles;
`endif

  int checks = 0;
  int errors = 0;

  // {pc_we, fd_we, fd_flush, dx_we, dx_bubble, xm_we, mw_we, halted}
  localparam logic [7:0] V_RESET  = 8'b0000_0000;
  localparam logic [7:0] V_RUN    = 8'b1101_0110;
  localparam logic [7:0] V_STALL  = 8'b0001_1110;
  localparam logic [7:0] V_BRANCH = 8'b1111_0110;
  localparam logic [7:0] V_HLT    = 8'b0111_0110;
  localparam logic [7:0] V_FREEZE = 8'b0000_0000;
  localparam logic [7:0] V_DRAIN  = 8'b0011_1110;
  localparam logic [7:0] V_DRAINB = 8'b0010_1000;
  localparam logic [7:0] V_HALTED = 8'b0000_0001;

  logic [7:0] exp_q[$];
  string      tag_q[$];

  pipeline_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall_sig      (stall_sig),
    .fd_branchtaken (fd_branchtaken),
    .fd_halt        (fd_halt),
    .dmem_busy      (dmem_busy),
    .pc_we          (pc_we),
    .fd_we          (fd_we),
    .fd_flush       (fd_flush),
    .dx_we          (dx_we),
    .dx_bubble      (dx_bubble),
    .xm_we          (xm_we),
    .mw_we          (mw_we),
    .halted         (halted)
`ifdef PIPE_PERF_CNT_EN
    ,
    .stall_cycles   (stall_cycles),
    .flush_cycles   (flush_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pop the oldest expectation and compare it with the sampled outputs
  task automatic sample_check();
    logic [7:0] obs;
    logic [7:0] exp_v;
    string      tag;
    obs   = {pc_we, fd_we, fd_flush, dx_we, dx_bubble, xm_we, mw_we, halted};
    exp_v = exp_q.pop_front();
    tag   = tag_q.pop_front();
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
    end
  endtask

  // Drive one cycle's inputs at the falling edge, check outputs 1ns later
  task automatic step(input string tag, input logic s, input logic t,
                      input logic h, input logic b, input logic [7:0] exp_v);
    @(negedge clk);
    stall_sig      = s;
    fd_branchtaken = t;
    fd_halt        = h;
    dmem_busy      = b;
    exp_q.push_back(exp_v);
    tag_q.push_back(tag);
    #1;
    sample_check();
  endtask

  // Assert reset asynchronously mid-cycle, check outputs drop, then release
  task automatic apply_reset(input string tag);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    exp_q.push_back(V_RESET);
    tag_q.push_back(tag);
    #1;
    sample_check();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n          = 1'b1;
    stall_sig      = 1'b0;
    fd_branchtaken = 1'b0;
    fd_halt        = 1'b0;
    dmem_busy      = 1'b0;

    // 1: reset, then normal flow
    apply_reset("reset_outputs");
    step("run0", 1'b0, 1'b0, 1'b0, 1'b0, V_RUN);
    step("run1", 1'b0, 1'b0, 1'b0, 1'b0, V_RUN);

    // 2: stall beats branch, branch taken the following cycle
    step("stall_over_branch", 1'b1, 1'b1, 1'b0, 1'b0, V_STALL);
    step("branch_flush",      1'b0, 1'b1, 1'b0, 1'b0, V_BRANCH);
    step("branch_one_cycle",  1'b0, 1'b0, 1'b0, 1'b0, V_RUN);

    // 3: memory freeze beats everything else
    step("freeze_over_stall", 1'b1, 1'b0, 1'b0, 1'b1, V_FREEZE);
    step("freeze_over_all",   1'b1, 1'b1, 1'b1, 1'b1, V_FREEZE);
    step("after_freeze",      1'b0, 1'b0, 1'b0, 1'b0, V_RUN);

    // 4: HLT, three drain cycles, then parked regardless of inputs
    step("hlt_decode", 1'b0, 1'b0, 1'b1, 1'b0, V_HLT);
    step("drain0",     1'b1, 1'b1, 1'b0, 1'b0, V_DRAIN);
    step("drain1",     1'b0, 1'b0, 1'b1, 1'b0, V_DRAIN);
    step("drain2",     1'b0, 1'b0, 1'b0, 1'b0, V_DRAIN);
    step("halted0",    1'b0, 1'b0, 1'b0, 1'b0, V_HALTED);
    step("halted_in1", 1'b1, 1'b1, 1'b1, 1'b0, V_HALTED);
    step("halted_in2", 1'b0, 1'b1, 1'b0, 1'b1, V_HALTED);

    // 5: busy memory stretches the drain by two cycles
    apply_reset("reset_from_halted");
    step("run_t5",       1'b0, 1'b0, 1'b0, 1'b0, V_RUN);
    step("hlt_t5",       1'b0, 1'b0, 1'b1, 1'b0, V_HLT);
    step("drain_busy0",  1'b0, 1'b0, 1'b0, 1'b1, V_DRAINB);
    step("drain_busy1",  1'b1, 1'b0, 1'b0, 1'b1, V_DRAINB);
    step("drain0_t5",    1'b0, 1'b0, 1'b0, 1'b0, V_DRAIN);
    step("drain1_t5",    1'b0, 1'b0, 1'b0, 1'b0, V_DRAIN);
    step("drain2_t5",    1'b0, 1'b0, 1'b0, 1'b0, V_DRAIN);
    step("halted_t5",    1'b0, 1'b0, 1'b0, 1'b0, V_HALTED);

    // 6: reset in the middle of a drain returns straight to RUN
    apply_reset("reset_pre_t6");
    step("hlt_t6",       1'b0, 1'b0, 1'b1, 1'b0, V_HLT);
    step("drain0_t6",    1'b0, 1'b0, 1'b0, 1'b0, V_DRAIN);
    apply_reset("reset_mid_drain");
    step("run_after_rst", 1'b0, 1'b0, 1'b0, 1'b0, V_RUN);
`ifdef PIPE_PERF_CNT_EN
    checks++;
    assert (stall_cycles === 16'd0 && flush_cycles === 16'd0) else begin
      errors++;
      $error("FAIL perf_cleared observed=%0d/%0d expected=0/0", stall_cycles, flush_cycles);
    end
`endif
    step("perf_stall0",  1'b1, 1'b0, 1'b0, 1'b0, V_STALL);
    step("perf_stall1",  1'b1, 1'b1, 1'b0, 1'b0, V_STALL);
    step("perf_busy",    1'b1, 1'b0, 1'b0, 1'b1, V_FREEZE);
    step("perf_stall2",  1'b1, 1'b0, 1'b0, 1'b0, V_STALL);
    step("perf_br0",     1'b0, 1'b1, 1'b0, 1'b0, V_BRANCH);
    step("perf_br1",     1'b0, 1'b1, 1'b0, 1'b0, V_BRANCH);
    step("perf_run",     1'b0, 1'b0, 1'b0, 1'b0, V_RUN);
`ifdef PIPE_PERF_CNT_EN
    checks++;
    assert (stall_cycles === 16'd3) else begin
      errors++;
      $error("FAIL perf_stall_cycles observed=%0d expected=3", stall_cycles);
    end
    checks++;
    assert (flush_cycles === 16'd2) else begin
      errors++;
      $error("FAIL perf_flush_cycles observed=%0d expected=2", flush_cycles);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
